// File: rtl/stream_chk_pkg.sv
// Shared types and defaults for the counter-stream checker.
// STREAM_CHK_INTERVAL_EN in the top adds strobe-spacing checks built on gap_width().
package stream_chk_pkg;

  typedef enum logic [1:0] {
    SEEK    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } chk_state_t;

  localparam int DEF_PERIOD     = 4;
  localparam int DEF_LOCK_COUNT = 2;
  localparam int DEF_DATA_W     = 8;
  localparam int DEF_ERR_W      = 8;

  // Leaves headroom so PERIOD+1 (the timeout value) is always representable.
  function automatic int gap_width(input int period);
    return $clog2(period) + 2;
  endfunction

endpackage

// File: rtl/stream_checker_gap_timer.sv
// Saturating clocks-since-last-strobe counter; timeout flags a strobe overdue by one clock.
// Used by stream_checker only when STREAM_CHK_INTERVAL_EN is defined.
module gap_timer #(
  parameter int PERIOD = 4,
  parameter int GAP_W  = 4
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_valid,
  output logic [GAP_W-1:0] o_gap,
  output logic             o_timeout
);

  localparam logic [GAP_W-1:0] LP_TIMEOUT = GAP_W'(PERIOD + 1);

  logic [GAP_W-1:0] r_gap;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_gap <= '0;
    end else if (i_valid) begin
      r_gap <= GAP_W'(1);
    end else if (r_gap != '1) begin
      r_gap <= r_gap + 1'b1;
    end
  end

  assign o_gap     = r_gap;
  assign o_timeout = (r_gap == LP_TIMEOUT);

endmodule

// File: rtl/stream_checker.sv
// Checks a strobed free-running counter stream: stride PERIOD per strobe, lock and error count.
// Define STREAM_CHK_INTERVAL_EN to also require strobes exactly PERIOD clocks apart.
//
// state   | meaning
// SEEK    | no reference; next strobe becomes the base sample
// ACQUIRE | counting consecutive matching strobes toward LOCK_COUNT
// LOCKED  | stream trusted; any mismatch (or timeout) is an error
module stream_checker
  import stream_chk_pkg::*;
#(
  parameter int PERIOD     = DEF_PERIOD,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int ERR_W      = DEF_ERR_W
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  input  logic              i_clear,
  output logic              o_locked,
  output logic              o_error,
  output logic [ERR_W-1:0]  o_err_count
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam logic [RUN_W-1:0]  LP_LOCK   = RUN_W'(LOCK_COUNT);
  localparam logic [DATA_W-1:0] LP_STRIDE = DATA_W'(PERIOD);

  chk_state_t        r_state, w_state_nxt;
  logic [DATA_W-1:0] r_base, w_base_nxt;
  logic [RUN_W-1:0]  r_run, w_run_nxt;
  logic              r_error, r_locked;
  logic [ERR_W-1:0]  r_err_count;
  logic              w_err_evt;
  logic              w_match;
  logic              w_interval_ok;
  logic              w_timeout;
  logic [RUN_W-1:0]  w_run_inc;

`ifdef STREAM_CHK_INTERVAL_EN
  localparam int GAP_W = gap_width(PERIOD);
  logic [GAP_W-1:0] w_gap;

  gap_timer #(
    .PERIOD (PERIOD),
    .GAP_W  (GAP_W)
  ) u_gap_timer (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_valid   (i_valid),
    .o_gap     (w_gap),
    .o_timeout (w_timeout)
  );

  assign w_interval_ok = (w_gap == GAP_W'(PERIOD));
`else
  assign w_interval_ok = 1'b1;
  assign w_timeout     = 1'b0;
`endif

  assign w_match   = (i_data == r_base + LP_STRIDE) && w_interval_ok;
  assign w_run_inc = r_run + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_base_nxt  = r_base;
    w_run_nxt   = r_run;
    w_err_evt   = 1'b0;
    case (r_state)
      SEEK: begin
        if (i_valid) begin
          w_base_nxt  = i_data;
          w_run_nxt   = '0;
          w_state_nxt = ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (i_valid) begin
          w_base_nxt = i_data;
          if (w_match) begin
            w_run_nxt = w_run_inc;
            if (w_run_inc == LP_LOCK) w_state_nxt = LOCKED;
          end else begin
            w_run_nxt = '0;
          end
        end
      end
      LOCKED: begin
        if (i_valid) begin
          w_base_nxt = i_data;
          if (!w_match) begin
            w_err_evt   = 1'b1;
            w_run_nxt   = '0;
            w_state_nxt = ACQUIRE;
          end
        end else if (w_timeout) begin
          w_err_evt   = 1'b1;
          w_state_nxt = SEEK;
        end
      end
      default: w_state_nxt = SEEK;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= SEEK;
      r_base   <= '0;
      r_run    <= '0;
      r_error  <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_base   <= w_base_nxt;
      r_run    <= w_run_nxt;
      r_error  <= w_err_evt;
      r_locked <= (w_state_nxt == LOCKED);
    end
  end

  // clear beats a same-cycle error; the error pulse itself is unaffected
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_err_count <= '0;
    end else if (i_clear) begin
      r_err_count <= '0;
    end else if (w_err_evt && (r_err_count != '1)) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign o_locked    = r_locked;
  assign o_error     = r_error;
  assign o_err_count = r_err_count;

endmodule

// File: tb/tb_stream_checker.sv
// Randomized and directed bench for stream_checker against a stride/elapsed-time model.
// Follows STREAM_CHK_INTERVAL_EN the same way the design does.
module tb_stream_checker;

  localparam int PERIOD     = 4;
  localparam int DATA_W     = 8;
  localparam int LOCK_COUNT = 2;
  localparam int ERR_W      = 2;
  localparam int ERR_MAX    = (1 << ERR_W) - 1;

  logic              i_clock;
  logic              i_reset_n;
  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic              i_clear;
  logic              o_locked;
  logic              o_error;
  logic [ERR_W-1:0]  o_err_count;

  int n_vec;
  int n_err;

  // reference model: 0 = hunting, 1 = acquiring, 2 = locked
  int          m_mode;
  int          m_run;
  int          m_cnt;
  logic [7:0]  m_base;
  bit          m_err;
  bit          m_locked;
`ifdef STREAM_CHK_INTERVAL_EN
  localparam int GAP_MAX = (1 << ($clog2(PERIOD) + 2)) - 1;
  int m_cyc;
  int m_last;
`endif

  stream_checker #(
    .PERIOD     (PERIOD),
    .DATA_W     (DATA_W),
    .LOCK_COUNT (LOCK_COUNT),
    .ERR_W      (ERR_W)
  ) dut (
    .i_clock     (i_clock),
    .i_reset_n   (i_reset_n),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .i_clear     (i_clear),
    .o_locked    (o_locked),
    .o_error     (o_error),
    .o_err_count (o_err_count)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode   = 0;
    m_run    = 0;
    m_cnt    = 0;
    m_base   = 8'h00;
    m_err    = 1'b0;
    m_locked = 1'b0;
`ifdef STREAM_CHK_INTERVAL_EN
    m_last = m_cyc;
`endif
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic c);
    bit         match;
    bit         err;
    logic [7:0] stride;
`ifdef STREAM_CHK_INTERVAL_EN
    int gap;
    gap = m_cyc - m_last;
    if (gap > GAP_MAX) gap = GAP_MAX;
`endif
    err    = 1'b0;
    stride = d - m_base;
    match  = (stride == 8'(PERIOD));
`ifdef STREAM_CHK_INTERVAL_EN
    if (gap != PERIOD) match = 1'b0;
`endif
    if (v) begin
      if (m_mode == 0) begin
        m_run  = 0;
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (match) begin
          m_run++;
          if (m_run == LOCK_COUNT) m_mode = 2;
        end else begin
          m_run = 0;
        end
      end else if (!match) begin
        err    = 1'b1;
        m_run  = 0;
        m_mode = 1;
      end
      m_base = d;
    end
`ifdef STREAM_CHK_INTERVAL_EN
    else if (m_mode == 2 && gap == PERIOD + 1) begin
      err    = 1'b1;
      m_mode = 0;
    end
    if (v) m_last = m_cyc;
    m_cyc++;
`endif
    m_err    = err;
    m_locked = (m_mode == 2);
    if (c) m_cnt = 0;
    else if (err && m_cnt < ERR_MAX) m_cnt++;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic tick(input logic v, input logic [7:0] d, input logic c);
    i_valid = v;
    i_data  = d;
    i_clear = c;
    model_step(v, d, c);
    @(posedge i_clock);
    #1;
    check_val("locked", {31'd0, o_locked}, {31'd0, m_locked});
    check_val("error", {31'd0, o_error}, {31'd0, m_err});
    check_val("err_count", 32'(o_err_count), 32'(m_cnt));
    @(negedge i_clock);
  endtask

  task automatic send(input logic [7:0] d, input logic c);
    repeat (PERIOD - 1) tick(1'b0, 8'($urandom), 1'b0);
    tick(1'b1, d, c);
  endtask

  task automatic do_reset();
    #2;
    i_reset_n = 1'b0;
    i_valid   = 1'b0;
    i_clear   = 1'b0;
    #1;
    check_val("rst_locked", {31'd0, o_locked}, 32'd0);
    check_val("rst_error", {31'd0, o_error}, 32'd0);
    check_val("rst_err_count", 32'(o_err_count), 32'd0);
    @(negedge i_clock);
    i_reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [7:0] d;
    int         phase;
    logic [7:0] gcnt;
    n_vec     = 0;
    n_err     = 0;
`ifdef STREAM_CHK_INTERVAL_EN
    m_cyc  = 0;
    m_last = 0;
`endif
    i_reset_n = 1'b0;
    i_valid   = 1'b0;
    i_clear   = 1'b0;
    i_data    = '0;
    repeat (3) @(posedge i_clock);
    #1;
    check_val("por_locked", {31'd0, o_locked}, 32'd0);
    check_val("por_error", {31'd0, o_error}, 32'd0);
    check_val("por_err_count", 32'(o_err_count), 32'd0);
    @(negedge i_clock);
    i_reset_n = 1'b1;
    model_reset();

    // lock-up
    send(8'h03, 1'b0);
    send(8'h07, 1'b0);
    send(8'h0B, 1'b0);
    check_val("lockup_locked", {31'd0, o_locked}, 32'd1);
    check_val("lockup_cnt", 32'(o_err_count), 32'd0);

    // wrap-around
    do_reset();
    send(8'hF3, 1'b0);
    send(8'hF7, 1'b0);
    send(8'hFB, 1'b0);
    send(8'hFF, 1'b0);
    send(8'h03, 1'b0);
    check_val("wrap_locked", {31'd0, o_locked}, 32'd1);
    check_val("wrap_error", {31'd0, o_error}, 32'd0);

    // data mismatch and relock
    send(8'h07, 1'b0);
    send(8'h0B, 1'b0);
    send(8'h10, 1'b0);
    check_val("mis_error", {31'd0, o_error}, 32'd1);
    check_val("mis_cnt", 32'(o_err_count), 32'd1);
    check_val("mis_locked", {31'd0, o_locked}, 32'd0);
    send(8'h14, 1'b0);
    send(8'h18, 1'b0);
    check_val("relock", {31'd0, o_locked}, 32'd1);

    // saturation and clear
    d = 8'h18;
    for (int i = 0; i < 4; i++) begin
      d = d + 8'd5;
      send(d, 1'b0);
      d = d + 8'd4;
      send(d, 1'b0);
      d = d + 8'd4;
      send(d, 1'b0);
    end
    check_val("sat_cnt", 32'(o_err_count), 32'(ERR_MAX));
    d = d + 8'd7;
    send(d, 1'b1);
    check_val("clr_cnt", 32'(o_err_count), 32'd0);
    check_val("clr_error", {31'd0, o_error}, 32'd1);
    d = d + 8'd4;
    send(d, 1'b0);
    d = d + 8'd4;
    send(d, 1'b0);
    d = d + 8'd9;
    send(d, 1'b0);
    d = d + 8'd4;
    send(d, 1'b0);
    d = d + 8'd4;
    send(d, 1'b0);
    check_val("pre_rst_locked", {31'd0, o_locked}, 32'd1);
    check_val("pre_rst_cnt", 32'(o_err_count), 32'd1);
    do_reset();

`ifdef STREAM_CHK_INTERVAL_EN
    // late strobe, then missing strobe
    send(8'h20, 1'b0);
    send(8'h24, 1'b0);
    send(8'h28, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    send(8'h2C, 1'b0);
    check_val("late_error", {31'd0, o_error}, 32'd1);
    check_val("late_locked", {31'd0, o_locked}, 32'd0);
    send(8'h30, 1'b0);
    send(8'h34, 1'b0);
    check_val("late_relock", {31'd0, o_locked}, 32'd1);
    repeat (5) tick(1'b0, 8'h00, 1'b0);
    check_val("timeout_error", {31'd0, o_error}, 32'd1);
    check_val("timeout_locked", {31'd0, o_locked}, 32'd0);
    send(8'h40, 1'b0);
    send(8'h44, 1'b0);
    check_val("seek_not_locked", {31'd0, o_locked}, 32'd0);
    send(8'h48, 1'b0);
    check_val("seek_relock", {31'd0, o_locked}, 32'd1);
`endif

    // randomized generator stream with injected faults
    phase = 0;
    gcnt  = 8'($urandom);
    for (int k = 0; k < 4000; k++) begin
      logic       v;
      logic       c;
      logic [7:0] dd;
      gcnt  = gcnt + 8'd1;
      phase = phase + 1;
      v     = (phase >= PERIOD);
      if (v) phase = 0;
      if (v && $urandom_range(0, 39) == 0) begin
        v     = 1'b0;
        phase = PERIOD - 1;
      end else if (v && $urandom_range(0, 59) == 0) begin
        v = 1'b0;
      end
      dd = gcnt;
      if (v && $urandom_range(0, 29) == 0) dd = gcnt ^ 8'($urandom_range(1, 255));
      if (!v) dd = 8'($urandom);
      c = ($urandom_range(0, 59) == 0);
      tick(v, dd, c);
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stream_checker.md
# stream_checker

Receive-side checker for the free-running counter stream produced by the team's test-pattern generators: an 8-bit `data` bus that increments every clock, with a one-cycle `valid` strobe every `PERIOD` clocks. It sits downstream of a generator and verifies that each strobed sample advances by exactly `PERIOD` modulo 2^`DATA_W`, and optionally that strobes arrive exactly `PERIOD` clocks apart. It reports lock status and a saturating error count. It provides the self-checking consumer side for generator unit tests.

## Interface
- `PERIOD`, 4: expected clocks between `valid` strobes and expected data stride; legal range 2..255.
- `DATA_W`, 8: data width.
- `LOCK_COUNT`, 2: consecutive matching samples required, after the base sample, before lock.
- `ERR_W`, 8: error counter width.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset; 0 resets all state immediately.
- `data`  in  DATA_W  generator data; sampled only when `valid`=1.
- `valid`  in  1  sample strobe.
- `clear`  in  1  synchronous; zeroes `err_count`.
- `locked`  out  1  registered; 1 while in LOCKED.
- `error`  out  1  registered one-cycle pulse per detected error.
- `err_count`  out  ERR_W  registered; saturates at all-ones.

## Operation
- States: SEEK, ACQUIRE, LOCKED. Reset state is SEEK.
- Registers:
  - `base` (DATA_W): last sampled data.
  - `run` (counts to LOCK_COUNT): consecutive-match counter.
  - `gap`: width clog2(PERIOD)+2; counts clocks since last strobe, saturates at all-ones. On a `valid` clock it loads 1; otherwise it increments.
- Match rule for a `valid` sample: `data == base + PERIOD` (mod 2^DATA_W, truncated add). With `STREAM_CHK_INTERVAL_EN`, a match also requires `gap == PERIOD`.
- SEEK, on `valid`: `base`←`data`, `run`←0, go to ACQUIRE.
- ACQUIRE, on `valid`:
  - Match: `base`←`data`, `run`++. If the incremented `run` equals LOCK_COUNT, go to LOCKED.
  - Mismatch: `base`←`data`, `run`←0, stay in ACQUIRE, no error.
- LOCKED, on `valid`:
  - Match: `base`←`data`.
  - Mismatch: pulse `error`, increment `err_count`, `base`←`data`, `run`←0, go to ACQUIRE.
- LOCKED timeout (interval check only): if `gap` reaches PERIOD+1 with no strobe, pulse `error`, increment `err_count`, go to SEEK.
- `clear` and an error in the same clock: `clear` wins (`err_count`=0), but `error` still pulses.
- At saturation `err_count` holds all-ones; `error` still pulses.
- Reset mid-stream: everything returns to reset values; the next strobe is treated as a SEEK base.

## Timing
- Reset values: `locked`=0, `error`=0, `err_count`=0, `base`=0, `run`=0, `gap`=0, state SEEK.
- `error` is high during the clock after the offending `valid` clock, or after the clock in which the timeout is detected.
- `locked` rises the clock after the LOCK_COUNT-th match and falls the clock after the error-causing event.
- `clear` takes effect on the next edge.
- No combinational path exists from any input to any output.

## Configuration
- `STREAM_CHK_INTERVAL_EN` defined:
  - Interval check and LOCKED timeout are compiled in.
  - `gap` register exists.
- `STREAM_CHK_INTERVAL_EN` undefined:
  - Only the data stride is checked.
  - `gap` logic is removed.
  - LOCKED is left only via a data mismatch.
  - Strobes may arrive at any spacing.

## Structure
- Shared package `stream_chk_pkg`:
  - State enum `chk_state_t` (SEEK, ACQUIRE, LOCKED).
  - Default constants for PERIOD, LOCK_COUNT, DATA_W.
- One sub-module, `gap_timer`:
  - Saturating since-last-strobe counter with `timeout` output.
  - Instantiated only under `STREAM_CHK_INTERVAL_EN`.

## Test plan
- Lock-up. PERIOD=4; strobes every 4 clocks with data 0x03, 0x07, 0x0B → `locked`=1 the clock after the 0x0B strobe; `err_count`=0.
- Wrap-around. Locked stream with data 0xFB, 0xFF, 0x03 → no error; `locked` stays 1.
- Data mismatch. Locked; next strobe carries 0x10 instead of 0x0F → one-clock `error` pulse, `err_count`=1, `locked`=0. Then 0x14 and 0x18 relock it.
- Interval fault (macro on). Locked; one strobe delayed to 5 clocks with correct data → `error` pulses, state returns to ACQUIRE. With no strobe for 5 clocks → `error`, state SEEK.
- Saturation and clear. ERR_W=2; force 4 mismatches → `err_count` holds 3. Assert `clear` in the same clock as a fifth error → `err_count`=0, `error` pulses.
- Async reset. Assert `reset`=0 mid-lock between clock edges → `locked`, `error`, and `err_count` go to 0 immediately.
